// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-back slice.
package rf_ctrl_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned NREG   = 2 ** ADDR_W;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_e;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundle of producer handshakes, RF write port, issue claim and hazard query signals.
interface rf_wb_arbiter_if;
    import rf_ctrl_pkg::*;

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_wreg;
    logic [DATA_W-1:0] alu_data;
    logic              lsu_valid;
    logic              lsu_ready;
    logic [ADDR_W-1:0] lsu_wreg;
    logic [DATA_W-1:0] lsu_data;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_wreg;
    logic [DATA_W-1:0] rf_wdata;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_wreg;
    logic              iss_ready;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic              rd_busy1;
    logic              rd_busy2;
    logic              sb_err;

    modport slave (
        input  alu_valid, alu_wreg, alu_data,
        input  lsu_valid, lsu_wreg, lsu_data,
        input  iss_valid, iss_wreg, rd_addr1, rd_addr2,
        output alu_ready, lsu_ready, rf_we, rf_wreg, rf_wdata,
        output iss_ready, rd_busy1, rd_busy2, sb_err
    );

    modport master (
        output alu_valid, alu_wreg, alu_data,
        output lsu_valid, lsu_wreg, lsu_data,
        output iss_valid, iss_wreg, rd_addr1, rd_addr2,
        input  alu_ready, lsu_ready, rf_we, rf_wreg, rf_wdata,
        input  iss_ready, rd_busy1, rd_busy2, sb_err
    );

endinterface

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Pending-write scoreboard: destination claims, commit clears, hazard lookups, sticky error.
module rf_scoreboard
    import rf_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_wreg,
    output logic              iss_ready,
    input  logic              commit,
    input  logic [ADDR_W-1:0] commit_reg,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    output logic              sb_err
);

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_next;

    assign iss_ready = !pending[iss_wreg];
    assign rd_busy1  = pending[rd_addr1];
    assign rd_busy2  = pending[rd_addr2];

    // Clear is applied before set so a same-index set/clear leaves the bit set.
    always_comb begin
        pending_next = pending;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (commit && commit_reg == ADDR_W'(i))
                pending_next[i] = 1'b0;
            if (iss_valid && iss_ready && iss_wreg == ADDR_W'(i))
                pending_next[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pending <= '0;
            sb_err  <= 1'b0;
        end else begin
            pending <= pending_next;
            if (commit && !pending[commit_reg])
                sb_err <= 1'b1;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin ALU/LSU write-back arbiter with a registered RF write port and pending scoreboard.
module rf_wb_arbiter
    import rf_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           rstn,
    rf_wb_arbiter_if.slave bus
);

    req_e              last_grant;
    logic              alu_gnt;
    logic              lsu_gnt;
    logic              we_q;
    logic [ADDR_W-1:0] wreg_q;
    logic [DATA_W-1:0] wdata_q;

    // On contention the requester that did not win last time is served.
    always_comb begin
        alu_gnt = bus.alu_valid && (!bus.lsu_valid || last_grant == REQ_LSU);
        lsu_gnt = bus.lsu_valid && (!bus.alu_valid || last_grant == REQ_ALU);
    end

    assign bus.alu_ready = alu_gnt;
    assign bus.lsu_ready = lsu_gnt;
    assign bus.rf_we     = we_q;
    assign bus.rf_wreg   = wreg_q;
    assign bus.rf_wdata  = wdata_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            we_q       <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
            last_grant <= REQ_LSU;
        end else begin
            we_q <= alu_gnt || lsu_gnt;
            if (alu_gnt) begin
                wreg_q     <= bus.alu_wreg;
                wdata_q    <= bus.alu_data;
                last_grant <= REQ_ALU;
            end else if (lsu_gnt) begin
                wreg_q     <= bus.lsu_wreg;
                wdata_q    <= bus.lsu_data;
                last_grant <= REQ_LSU;
            end
        end
    end

    rf_scoreboard u_sb (
        .clk        (clk),
        .rstn       (rstn),
        .iss_valid  (bus.iss_valid),
        .iss_wreg   (bus.iss_wreg),
        .iss_ready  (bus.iss_ready),
        .commit     (we_q),
        .commit_reg (wreg_q),
        .rd_addr1   (bus.rd_addr1),
        .rd_addr2   (bus.rd_addr2),
        .rd_busy1   (bus.rd_busy1),
        .rd_busy2   (bus.rd_busy2),
        .sb_err     (bus.sb_err)
    );

endmodule
